ex_branch_unit: RTL and testbench

EX_BRANCH_UNIT -- requirements
Module: ex_branch_unit

---
 rtl/ex_branch_unit.sv | 179 +++++++++++++++++
 tb/tb_ex_branch_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_branch_unit.sv
// Execute-stage branch/jump unit: resolves conditional branches, JAL/JALR and AUIPC,
// holds one result until both the writeback and the fetch-redirect handshakes finish.
module ex_branch_unit #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rd,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_rd_data,
    output logic             out_rd_en,
    output logic             out_exc,
    output logic [XLEN-1:0]  out_badaddr,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);

    typedef enum logic [3:0] {
        OP_BEQ   = 4'd0,
        OP_BNE   = 4'd1,
        OP_BLT   = 4'd2,
        OP_BGE   = 4'd3,
        OP_BLTU  = 4'd4,
        OP_BGEU  = 4'd5,
        OP_JAL   = 4'd6,
        OP_JALR  = 4'd7,
        OP_AUIPC = 4'd8
    } op_e;

    typedef enum logic {S_EMPTY, S_HOLD} state_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    state_e          state_q, state_d;
    logic            accept;
    logic            out_clear, redir_clear;
    logic            is_ctrl_q;

    logic [XLEN-1:0] pc_imm, pc_4, jalr_tgt, target, rd_data_c;
    logic            taken_c, is_ctrl_c, writes_rd_c;
    logic            misaligned_c, mispred_c, redirect_c, rd_en_c;

    // Resolve the incoming instruction; everything here is captured on accept.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_imm      = in_pc + in_imm;
        pc_4        = in_pc + XLEN'(4);
        jalr_tgt    = (in_rs1 + in_imm) & ~XLEN'(1);
        target      = pc_imm;
        taken_c     = 1'b0;
        is_ctrl_c   = 1'b0;
        writes_rd_c = 1'b0;
        rd_data_c   = '0;
        case (in_op)
            OP_BEQ:  begin is_ctrl_c = 1'b1; taken_c = (in_rs1 == in_rs2); end
            OP_BNE:  begin is_ctrl_c = 1'b1; taken_c = (in_rs1 != in_rs2); end
            OP_BLT:  begin is_ctrl_c = 1'b1; taken_c = ($signed(in_rs1) <  $signed(in_rs2)); end
            OP_BGE:  begin is_ctrl_c = 1'b1; taken_c = ($signed(in_rs1) >= $signed(in_rs2)); end
            OP_BLTU: begin is_ctrl_c = 1'b1; taken_c = (in_rs1 <  in_rs2); end
            OP_BGEU: begin is_ctrl_c = 1'b1; taken_c = (in_rs1 >= in_rs2); end
            OP_JAL: begin
                is_ctrl_c   = 1'b1;
                taken_c     = 1'b1;
                writes_rd_c = 1'b1;
                rd_data_c   = pc_4;
            end
            OP_JALR: begin
                is_ctrl_c   = 1'b1;
                taken_c     = 1'b1;
                writes_rd_c = 1'b1;
                rd_data_c   = pc_4;
                target      = jalr_tgt;
            end
            OP_AUIPC: begin
                writes_rd_c = 1'b1;
                rd_data_c   = pc_imm;
            end
            default: ;
        endcase

        misaligned_c = taken_c && ((target & ALIGN_MASK) != '0);
        rd_en_c      = writes_rd_c && (in_rd != 5'd0) && !misaligned_c;
        mispred_c    = is_ctrl_c && ((taken_c != in_pred_taken) ||
                       (taken_c && in_pred_taken && (target != in_pred_target)));
        redirect_c   = mispred_c && !misaligned_c;
    end

    // A handshake is "clear" if it is not pending or completes this cycle.
    assign out_clear   = !out_valid   || out_ready;
    assign redir_clear = !redir_valid || redir_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_EMPTY: in_ready = 1'b1;
            S_HOLD:  in_ready = out_clear && redir_clear;
            default: in_ready = 1'b0;
        endcase
        if (flush || !rst)
            in_ready = 1'b0;
        accept = in_valid && in_ready;

        if (flush)
            state_d = S_EMPTY;
        else if (accept)
            state_d = S_HOLD;
        else if (state_q == S_HOLD && out_clear && redir_clear)
            state_d = S_EMPTY;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_EMPTY;
        else
            state_q <= state_d;
    end

    // NOTE: the whole result/counter bank is reset, since reset must leave every output at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            redir_valid <= 1'b0;
            out_rd      <= '0;
            out_rd_data <= '0;
            out_rd_en   <= 1'b0;
            out_exc     <= 1'b0;
            out_badaddr <= '0;
            redir_pc    <= '0;
            is_ctrl_q   <= 1'b0;
            cnt_branch  <= '0;
            cnt_mispred <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            redir_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (is_ctrl_q)
                    cnt_branch <= cnt_branch + CNT_W'(1);
            end
            if (redir_valid && redir_ready) begin
                redir_valid <= 1'b0;
                cnt_mispred <= cnt_mispred + CNT_W'(1);
            end
            // A new entry overrides the completion clears above (back-to-back issue).
            if (accept) begin
                out_valid   <= 1'b1;
                redir_valid <= redirect_c;
                out_rd      <= in_rd;
                out_rd_data <= rd_data_c;
                out_rd_en   <= rd_en_c;
                out_exc     <= misaligned_c;
                out_badaddr <= misaligned_c ? target : '0;
                redir_pc    <= taken_c ? target : pc_4;
                is_ctrl_q   <= is_ctrl_c;
            end
        end
    end

endmodule

// File: tb/tb_ex_branch_unit.sv
// Self-checking bench for ex_branch_unit: transaction-level reference model plus
// directed vectors with hand-computed literal expectations.
module tb_ex_branch_unit;

    localparam int IALIGN_TB = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        pt;
        logic [31:0] ptgt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rd_en;
        logic [31:0] rd_data;
        logic        exc;
        logic [31:0] badaddr;
        logic        redirect;
        logic [31:0] redir_pc;
        logic        is_ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0, in_valid2 = 1'b0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pred_target = '0;
    logic [4:0]  in_rd = '0;
    logic        in_pred_taken = 1'b0;
    logic        out_ready = 1'b0, redir_ready = 1'b0;

    logic        in_ready, out_valid, out_rd_en, out_exc, redir_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_rd_data, out_badaddr, redir_pc, cnt_branch, cnt_mispred;

    logic        in_ready2, out_valid2, out_rd_en2, out_exc2, redir_valid2;
    logic [4:0]  out_rd2;
    logic [31:0] out_rd_data2, out_badaddr2, redir_pc2, cnt_branch2, cnt_mispred2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_branch_unit #(.XLEN(32), .IALIGN(IALIGN_TB), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_data(out_rd_data), .out_rd_en(out_rd_en), .out_exc(out_exc),
        .out_badaddr(out_badaddr), .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    ex_branch_unit #(.XLEN(32), .IALIGN(2), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_op(in_op), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid2), .out_ready(out_ready), .out_rd(out_rd2),
        .out_rd_data(out_rd_data2), .out_rd_en(out_rd_en2), .out_exc(out_exc2),
        .out_badaddr(out_badaddr2), .redir_valid(redir_valid2), .redir_ready(redir_ready),
        .redir_pc(redir_pc2), .cnt_branch(cnt_branch2), .cnt_mispred(cnt_mispred2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd,
                                 input logic pt, input logic [31:0] ptgt);
        vec_t v;
        v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.rd = rd; v.pt = pt; v.ptgt = ptgt;
        return v;
    endfunction

    // Reference semantics of one instruction, written from the ISA rules.
    function automatic exp_t predict(input vec_t v);
        exp_t        e;
        logic        taken;
        logic [31:0] sum, tgt;
        int          sa, sb;
        e     = '0;
        sa    = v.rs1;
        sb    = v.rs2;
        sum   = v.pc + v.imm;
        tgt   = sum;
        taken = 1'b0;
        case (v.op)
            4'd0: taken = (v.rs1 == v.rs2);
            4'd1: taken = (v.rs1 != v.rs2);
            4'd2: taken = (sa < sb);
            4'd3: taken = (sa >= sb);
            4'd4: taken = (v.rs1 < v.rs2);
            4'd5: taken = (v.rs1 >= v.rs2);
            4'd6: taken = 1'b1;
            4'd7: begin taken = 1'b1; sum = v.rs1 + v.imm; tgt = sum - (sum % 2); end
            default: ;
        endcase
        e.is_ctrl = (v.op <= 4'd7);
        e.rd      = v.rd;
        e.exc     = taken && ((tgt % IALIGN_TB) != 0);
        e.badaddr = tgt;
        if (v.op == 4'd6 || v.op == 4'd7) e.rd_data = v.pc + 32'd4;
        else if (v.op == 4'd8)            e.rd_data = v.pc + v.imm;
        e.rd_en    = (v.op == 4'd6 || v.op == 4'd7 || v.op == 4'd8) && (v.rd != 5'd0) && !e.exc;
        e.redirect = e.is_ctrl && ((taken != v.pt) || (taken && tgt != v.ptgt)) && !e.exc;
        e.redir_pc = taken ? tgt : v.pc + 32'd4;
        return e;
    endfunction

    // Model state: what is owed on each channel, and how many retirements were seen.
    logic        m_out = 1'b0, m_redir = 1'b0;
    exp_t        m_e = '0;
    logic [31:0] m_cb = '0, m_cm = '0;
    logic        exp_in_ready;

    assign exp_in_ready = rst && !flush && (!m_out || out_ready) && (!m_redir || redir_ready);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out <= 1'b0; m_redir <= 1'b0; m_cb <= '0; m_cm <= '0;
        end else if (flush) begin
            m_out <= 1'b0; m_redir <= 1'b0;
        end else begin
            if (m_out && out_ready) begin
                m_out <= 1'b0;
                if (m_e.is_ctrl) m_cb <= m_cb + 32'd1;
            end
            if (m_redir && redir_ready) begin
                m_redir <= 1'b0;
                m_cm    <= m_cm + 32'd1;
            end
            if (in_valid && exp_in_ready) begin
                m_e     <= predict(mkv(in_op, in_pc, in_rs1, in_rs2, in_imm, in_rd,
                                       in_pred_taken, in_pred_target));
                m_out   <= 1'b1;
                m_redir <= predict(mkv(in_op, in_pc, in_rs1, in_rs2, in_imm, in_rd,
                                       in_pred_taken, in_pred_target)).redirect;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_redir_valid", redir_valid, 0);
            check("rst_out_rd", out_rd, 0);
            check("rst_rd_data", out_rd_data, 0);
            check("rst_rd_en", out_rd_en, 0);
            check("rst_exc", out_exc, 0);
            check("rst_badaddr", out_badaddr, 0);
            check("rst_redir_pc", redir_pc, 0);
            check("rst_cnt_branch", cnt_branch, 0);
            check("rst_cnt_mispred", cnt_mispred, 0);
        end else begin
            check("in_ready", in_ready, exp_in_ready);
            check("out_valid", out_valid, m_out);
            check("redir_valid", redir_valid, m_redir);
            check("cnt_branch", cnt_branch, m_cb);
            check("cnt_mispred", cnt_mispred, m_cm);
            if (m_out) begin
                check("out_rd", out_rd, m_e.rd);
                check("out_rd_en", out_rd_en, m_e.rd_en);
                check("out_exc", out_exc, m_e.exc);
                if (m_e.rd_en) check("out_rd_data", out_rd_data, m_e.rd_data);
                if (m_e.exc)   check("out_badaddr", out_badaddr, m_e.badaddr);
            end
            if (m_redir) check("redir_pc", redir_pc, m_e.redir_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold in_valid until accepted; returns just after the accepting edge.
    task automatic issue(input vec_t v, input bit also2, input bit rand_rdy);
        bit ok;
        ok = 1'b0;
        in_op = v.op; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        in_rd = v.rd; in_pred_taken = v.pt; in_pred_target = v.ptgt;
        in_valid = 1'b1; in_valid2 = also2;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
            if (rand_rdy) begin
                out_ready   = 1'($urandom_range(0, 1));
                redir_ready = 1'($urandom_range(0, 1));
            end
        end
        check("issue_accepted", ok, 1);
        step();
        in_valid = 1'b0; in_valid2 = 1'b0;
    endtask

    vec_t vq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("lit_reset_in_ready", in_ready, 0);
        check("lit_reset_out_valid", out_valid, 0);
        step();
        rst = 1'b1;

        // Mispredicted not-taken BEQ that is actually taken.
        issue(mkv(4'd0, 32'h100, 32'd5, 32'd5, 32'h20, 5'd3, 1'b0, 32'h0), 1'b0, 1'b0);
        @(negedge clk);
        check("beq_out_valid", out_valid, 1);
        check("beq_redir_valid", redir_valid, 1);
        check("beq_redir_pc", redir_pc, 32'h120);
        check("beq_rd_en", out_rd_en, 0);
        step();
        out_ready = 1'b1; redir_ready = 1'b1;
        @(negedge clk);
        check("beq_in_ready_both_done", in_ready, 1);
        step();
        @(negedge clk);
        check("beq_cnt_branch", cnt_branch, 1);
        check("beq_cnt_mispred", cnt_mispred, 1);
        check("beq_out_valid_done", out_valid, 0);
        step();

        // Signed vs unsigned compare of the same operands.
        issue(mkv(4'd2, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 1'b1, 32'h210), 1'b0, 1'b0);
        @(negedge clk);
        check("blt_out_valid", out_valid, 1);
        check("blt_no_redir", redir_valid, 0);
        step();
        issue(mkv(4'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 1'b1, 32'h210), 1'b0, 1'b0);
        @(negedge clk);
        check("bltu_redir_valid", redir_valid, 1);
        check("bltu_redir_pc", redir_pc, 32'h204);
        step();

        // JALR to an odd-halfword target: faults at IALIGN=4, legal at IALIGN=2.
        issue(mkv(4'd7, 32'h40, 32'h203, 32'd0, 32'h0, 5'd1, 1'b0, 32'h0), 1'b1, 1'b0);
        @(negedge clk);
        check("jalr4_exc", out_exc, 1);
        check("jalr4_badaddr", out_badaddr, 32'h202);
        check("jalr4_rd_en", out_rd_en, 0);
        check("jalr4_redir_valid", redir_valid, 0);
        check("jalr2_out_valid", out_valid2, 1);
        check("jalr2_exc", out_exc2, 0);
        check("jalr2_rd_en", out_rd_en2, 1);
        check("jalr2_rd_data", out_rd_data2, 32'h44);
        check("jalr2_redir_valid", redir_valid2, 1);
        check("jalr2_redir_pc", redir_pc2, 32'h202);
        step();

        // Redirect held back for three cycles while the next instruction waits.
        redir_ready = 1'b0; out_ready = 1'b1;
        issue(mkv(4'd1, 32'h300, 32'd1, 32'd2, 32'h40, 5'd0, 1'b0, 32'h0), 1'b0, 1'b0);
        in_op = 4'd8; in_pc = 32'h400; in_imm = 32'h1000; in_rd = 5'd5;
        in_pred_taken = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_redir_valid", redir_valid, 1);
            check("stall_redir_pc", redir_pc, 32'h340);
            step();
        end
        redir_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("auipc_out_valid", out_valid, 1);
        check("auipc_rd_data", out_rd_data, 32'h1400);
        check("auipc_rd_en", out_rd_en, 1);
        check("auipc_redir_valid", redir_valid, 0);
        check("auipc_cnt_branch", cnt_branch, 5);
        check("auipc_cnt_mispred", cnt_mispred, 3);
        step();

        // Flush of a held entry with a pending redirect, even with both readies high.
        out_ready = 1'b0; redir_ready = 1'b0;
        issue(mkv(4'd0, 32'h500, 32'd7, 32'd7, 32'h8, 5'd0, 1'b0, 32'h0), 1'b0, 1'b0);
        flush = 1'b1; out_ready = 1'b1; redir_ready = 1'b1;
        in_op = 4'd1; in_rs1 = 32'd1; in_rs2 = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_redir_valid", redir_valid, 0);
        check("flush_cnt_branch", cnt_branch, 5);
        check("flush_cnt_mispred", cnt_mispred, 3);
        step();

        // pc + 4 wraps to zero.
        issue(mkv(4'd6, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 5'd0, 1'b1, 32'h4), 1'b0, 1'b0);
        @(negedge clk);
        check("jal_wrap_rd_data", out_rd_data, 32'h0);
        check("jal_wrap_rd_en", out_rd_en, 0);
        check("jal_wrap_redir_valid", redir_valid, 0);
        step();
        issue(mkv(4'd6, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 5'd2, 1'b1, 32'h4), 1'b0, 1'b0);
        @(negedge clk);
        check("jal_wrap_rd2_data", out_rd_data, 32'h0);
        check("jal_wrap_rd2_en", out_rd_en, 1);
        step();

        vq.push_back(mkv(4'd0, 32'h1000, 32'd3, 32'd4, 32'h40, 5'd0, 1'b0, 32'h0));
        vq.push_back(mkv(4'd1, 32'h1004, 32'd9, 32'd9, 32'h40, 5'd0, 1'b1, 32'h1044));
        vq.push_back(mkv(4'd2, 32'h1008, 32'd5, 32'hFFFF_FFFD, 32'h100, 5'd0, 1'b1, 32'h1108));
        vq.push_back(mkv(4'd3, 32'h100C, 32'hFFFF_FFFD, 32'd5, 32'h20, 5'd0, 1'b0, 32'h0));
        vq.push_back(mkv(4'd3, 32'h1010, 32'd5, 32'hFFFF_FFFD, 32'h20, 5'd0, 1'b1, 32'h1030));
        vq.push_back(mkv(4'd4, 32'h1014, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 5'd0, 1'b0, 32'h0));
        vq.push_back(mkv(4'd5, 32'h1018, 32'd1, 32'hFFFF_FFFF, 32'h8, 5'd0, 1'b1, 32'h1020));
        vq.push_back(mkv(4'd0, 32'h101C, 32'd2, 32'd2, 32'h6, 5'd0, 1'b0, 32'h0));
        vq.push_back(mkv(4'd6, 32'h1020, 32'd0, 32'd0, 32'h100, 5'd7, 1'b1, 32'h1200));
        vq.push_back(mkv(4'd7, 32'h1024, 32'h3001, 32'd0, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h3000));
        vq.push_back(mkv(4'd7, 32'h1028, 32'h3005, 32'd0, 32'h0, 5'd9, 1'b1, 32'h3004));
        vq.push_back(mkv(4'd8, 32'h102C, 32'd0, 32'd0, 32'h1234_5000, 5'd10, 1'b1, 32'h0));
        vq.push_back(mkv(4'd9, 32'h1030, 32'd0, 32'd0, 32'h10, 5'd3, 1'b1, 32'h0));
        vq.push_back(mkv(4'd15, 32'h1034, 32'd1, 32'd1, 32'h10, 5'd4, 1'b0, 32'h0));
        vq.push_back(mkv(4'd8, 32'h1038, 32'd0, 32'd0, 32'h1000, 5'd0, 1'b0, 32'h0));
        vq.push_back(mkv(4'd6, 32'h103C, 32'd0, 32'd0, 32'h80, 5'd0, 1'b0, 32'h0));

        out_ready = 1'b1; redir_ready = 1'b1;
        foreach (vq[i]) issue(vq[i], 1'b0, 1'b0);
        foreach (vq[i]) issue(vq[i], 1'b0, 1'b1);

        out_ready = 1'b1; redir_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset while an entry and a redirect are held.
        out_ready = 1'b0; redir_ready = 1'b0;
        issue(mkv(4'd3, 32'h600, 32'd1, 32'd2, 32'h10, 5'd0, 1'b1, 32'h610), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_redir_valid", redir_valid, 0);
        check("arst_redir_pc", redir_pc, 0);
        check("arst_cnt_branch", cnt_branch, 0);
        check("arst_cnt_mispred", cnt_mispred, 0);
        check("arst_in_ready", in_ready, 0);
        @(negedge clk);
        step();
        rst = 1'b1;
        out_ready = 1'b1; redir_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
